// File: rtl/lpc_pkg.sv
// Shared types and LAD encodings for the LPC I/O target.
package lpc_pkg;

  typedef enum logic [2:0] {
    IDLE, CYCTYPE, ADDR, WDATA, HTAR, SYNC, RDATA, PTAR
  } lpc_state_e;

  localparam logic [3:0] CYC_IO_RD  = 4'h0;
  localparam logic [3:0] CYC_IO_WR  = 4'h2;
  localparam logic [3:0] SYNC_READY = 4'h0;
  localparam logic [3:0] SYNC_SWAIT = 4'h5;
  localparam logic [3:0] LAD_START  = 4'h0;
  localparam logic [3:0] LAD_IDLE   = 4'hF;

endpackage

// File: rtl/lpc_io_target_if.sv
// LPC pad signals plus the register-file strobe port of the I/O target.
interface lpc_io_target_if;
  logic       LFRAME_N;
  logic [3:0] LadIn;
  logic [3:0] LadOut;
  logic       LadOe;
  logic [7:0] RdData;
  logic [7:0] Addr;
  logic       Wr;
  logic       Rd;
  logic [7:0] DataWrSW;

  modport master (
    output LFRAME_N, LadIn, RdData,
    input  LadOut, LadOe, Addr, Wr, Rd, DataWrSW
  );

  modport slave (
    input  LFRAME_N, LadIn, RdData,
    output LadOut, LadOe, Addr, Wr, Rd, DataWrSW
  );
endinterface

// File: rtl/lpc_io_target.sv
// LPC I/O read/write target decoding a 32-byte window into register-file strobes.
// Optional LPC_SYNC_WAIT_EN inserts WAIT_CYCLES short-wait SYNC nibbles before ready.
module lpc_io_target
  import lpc_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h0800,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic             LpcClock,
  input  logic             PciReset,
  lpc_io_target_if.slave   bus
);

  if (BASE_ADDR[4:0] != 5'd0 || WAIT_CYCLES < 1) begin : g_bad_param
    $error("lpc_io_target: BASE_ADDR must be 32-byte aligned and WAIT_CYCLES >= 1");
  end

  lpc_state_e  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        is_wr_q;
  logic [11:0] addr_sh_q;
  logic [7:0]  addr_q, wdata_q, rd_q;
  logic [15:0] io_addr;
  logic        addr_hit, load_addr, sync_ready;
  logic        wr, rd, lad_oe;
  logic [3:0]  lad_out;

  assign io_addr  = {addr_sh_q, bus.LadIn};
  assign addr_hit = (io_addr[15:5] == BASE_ADDR[15:5]);

`ifdef LPC_SYNC_WAIT_EN
  localparam int WAIT_W = $clog2(WAIT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_q;

  // Cleared whenever SYNC is left, including by abort, so every SYNC starts fresh.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset)                                 wait_q <= '0;
    else if (state_q == SYNC && state_d == SYNC)   wait_q <= wait_q + 1'b1;
    else                                           wait_q <= '0;
  end
  assign sync_ready = (wait_q == WAIT_W'(WAIT_CYCLES));
`else
  assign sync_ready = 1'b1;
`endif

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    wr        = 1'b0;
    rd        = 1'b0;
    load_addr = 1'b0;
    lad_oe    = 1'b0;
    lad_out   = LAD_IDLE;
    unique case (state_q)
      IDLE: ;
      CYCTYPE:
        state_d = (bus.LadIn == CYC_IO_RD || bus.LadIn == CYC_IO_WR) ? ADDR : IDLE;
      ADDR:
        if (cnt_q == 2'd3) begin
          load_addr = addr_hit;
          state_d   = !addr_hit ? IDLE : (is_wr_q ? WDATA : HTAR);
        end else cnt_d = cnt_q + 2'd1;
      WDATA:
        if (cnt_q == 2'd1) state_d = HTAR; else cnt_d = cnt_q + 2'd1;
      HTAR:
        if (cnt_q == 2'd1) state_d = SYNC; else cnt_d = cnt_q + 2'd1;
      SYNC: begin
        lad_oe  = 1'b1;
        lad_out = sync_ready ? SYNC_READY : SYNC_SWAIT;
        if (sync_ready) begin
          wr      = is_wr_q;
          rd      = !is_wr_q;
          state_d = is_wr_q ? PTAR : RDATA;
        end
      end
      RDATA: begin
        lad_oe  = 1'b1;
        lad_out = cnt_q[0] ? rd_q[7:4] : rd_q[3:0];
        if (cnt_q == 2'd1) state_d = PTAR; else cnt_d = cnt_q + 2'd1;
      end
      PTAR:
        if (cnt_q == 2'd0) begin
          lad_oe = 1'b1;
          cnt_d  = 2'd1;
        end else state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A framed clock restarts or aborts from any state and suppresses this clock's strobes.
    if (!bus.LFRAME_N) begin
      state_d   = (bus.LadIn == LAD_START) ? CYCTYPE : IDLE;
      cnt_d     = '0;
      wr        = 1'b0;
      rd        = 1'b0;
      load_addr = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; only registers, not memories, are reset.
  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge LpcClock or negedge PciReset) begin
    if (!PciReset) begin
      cnt_q     <= '0;
      is_wr_q   <= 1'b0;
      addr_sh_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (state_q == CYCTYPE && bus.LFRAME_N) is_wr_q <= (bus.LadIn == CYC_IO_WR);
      if (state_q == ADDR) addr_sh_q <= io_addr[11:0];
      if (load_addr) addr_q <= {3'b000, io_addr[4:0]};
      if (state_q == WDATA && bus.LFRAME_N) begin
        if (cnt_q == 2'd0) wdata_q[3:0] <= bus.LadIn;
        else               wdata_q[7:4] <= bus.LadIn;
      end
      // Captured on the Rd edge so read-to-clear bits return their pre-clear value.
      if (rd) rd_q <= bus.RdData;
    end
  end

  assign bus.LadOut   = lad_out;
  assign bus.LadOe    = lad_oe;
  assign bus.Wr       = wr;
  assign bus.Rd       = rd;
  assign bus.Addr     = addr_q;
  assign bus.DataWrSW = wdata_q;

endmodule

// File: tb/tb_lpc_io_target.sv
// Scoreboard bench for lpc_io_target: cycle-level LPC host driver plus an event-list model.
module tb_lpc_io_target;
  import lpc_pkg::*;

  localparam logic [15:0] BASE = 16'h0800;
`ifdef LPC_SYNC_WAIT_EN
  localparam int W = 2;
`else
  localparam int W = 0;
`endif

  logic LpcClock = 1'b0;
  logic PciReset = 1'b0;
  lpc_io_target_if bus ();

  lpc_io_target #(.BASE_ADDR(BASE), .WAIT_CYCLES(2)) dut (
    .LpcClock (LpcClock),
    .PciReset (PciReset),
    .bus      (bus)
  );

  always #15 LpcClock = ~LpcClock;

  logic [7:0] regmem [256];
  assign bus.RdData = regmem[bus.Addr];

  int cyc = 0;
  always @(posedge LpcClock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { int cyc; logic [3:0] val; } lad_exp_t;
  typedef struct { int cyc; bit is_wr; logic [7:0] addr; logic [7:0] data; } strb_exp_t;
  lad_exp_t  lad_q [$];
  strb_exp_t strb_q [$];
  lad_exp_t  le;
  strb_exp_t se;
  logic [7:0] exp_addr = 8'h00;

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  always @(negedge LpcClock) begin
    if (PciReset) begin
      if (bus.LadOe) begin
        if (lad_q.size() == 0) check("lad_unexpected_drive", 32'(bus.LadOe), 32'd0);
        else begin
          le = lad_q.pop_front();
          check("lad_cycle", cyc, le.cyc);
          check("lad_value", 32'(bus.LadOut), 32'(le.val));
        end
      end
      if (bus.Wr || bus.Rd) begin
        if (strb_q.size() == 0) check("strobe_unexpected", 32'({bus.Wr, bus.Rd}), 32'd0);
        else begin
          se = strb_q.pop_front();
          check("strobe_cycle", cyc, se.cyc);
          check("strobe_kind", 32'({bus.Wr, bus.Rd}), se.is_wr ? 32'd2 : 32'd1);
          check("strobe_addr", 32'(bus.Addr), 32'(se.addr));
          if (se.is_wr) check("strobe_wdata", 32'(bus.DataWrSW), 32'(se.data));
        end
      end
    end
  end

  task automatic drive(input logic fr, input logic [3:0] lad);
    @(posedge LpcClock);
    #1;
    bus.LFRAME_N = fr;
    bus.LadIn    = lad;
  endtask

  // Reference: a completed cycle shows SYNC (after W waits), read data and one 4'hF nibble.
  task automatic expect_cycle(input int start, input bit is_wr, input logic [15:0] a,
                              input logic [7:0] d, input bit with_tail);
    int ready;
    logic [7:0] rv;
    ready = start + (is_wr ? 10 : 8) + W;
    rv    = regmem[{3'b000, a[4:0]}];
    for (int i = 0; i < W; i++) lad_q.push_back('{ready - W + i, SYNC_SWAIT});
    lad_q.push_back('{ready, SYNC_READY});
    strb_q.push_back('{ready, is_wr, {3'b000, a[4:0]}, d});
    if (with_tail) begin
      if (!is_wr) begin
        lad_q.push_back('{ready + 1, rv[3:0]});
        lad_q.push_back('{ready + 2, rv[7:4]});
      end
      lad_q.push_back('{ready + (is_wr ? 1 : 3), 4'hF});
    end
  endtask

  task automatic lpc_cycle(input bit is_wr, input logic [15:0] a, input logic [7:0] d,
                           input int abort_at, input int gap);
    logic [3:0] host [8];
    int start, nhost;
    bit hit;
    hit     = (a[15:5] == BASE[15:5]);
    host[0] = LAD_START;
    host[1] = is_wr ? CYC_IO_WR : CYC_IO_RD;
    host[2] = a[15:12]; host[3] = a[11:8]; host[4] = a[7:4]; host[5] = a[3:0];
    host[6] = d[3:0];   host[7] = d[7:4];
    nhost   = is_wr ? 8 : 6;
    drive(1'b0, host[0]);
    start = cyc;
    if (hit && abort_at < 0) expect_cycle(start, is_wr, a, d, 1'b1);
    if (hit && (abort_at < 0 || abort_at > 5)) exp_addr = {3'b000, a[4:0]};
    for (int p = 1; p <= 12 + W; p++) begin
      if (p == abort_at) drive(1'b0, 4'hF);
      else               drive(1'b1, (p < nhost) ? host[p] : 4'hF);
    end
    repeat (gap) drive(1'b1, 4'hF);
    check("addr_hold", 32'(bus.Addr), 32'(exp_addr));
  endtask

  task automatic reset_in_rdata();
    logic [15:0] a;
    a = 16'h0807;
    drive(1'b0, LAD_START);
    expect_cycle(cyc, 1'b0, a, 8'h00, 1'b0);
    drive(1'b1, CYC_IO_RD);
    drive(1'b1, a[15:12]); drive(1'b1, a[11:8]); drive(1'b1, a[7:4]); drive(1'b1, a[3:0]);
    for (int p = 6; p <= 8 + W; p++) drive(1'b1, 4'hF);
    @(posedge LpcClock);
    #1;
    PciReset = 1'b0;
    #1;
    check("rst_mid_lad_oe", 32'(bus.LadOe), 32'd0);
    check("rst_mid_rd", 32'(bus.Rd), 32'd0);
    check("rst_mid_lad_out", 32'(bus.LadOut), 32'hF);
    check("rst_mid_addr", 32'(bus.Addr), 32'd0);
    exp_addr = 8'h00;
    repeat (2) drive(1'b1, 4'hF);
    PciReset = 1'b1;
    repeat (2) drive(1'b1, 4'hF);
  endtask

  initial begin
    logic [15:0] a;
    bit wr_sel;
    int ab;
    bus.LFRAME_N = 1'b1;
    bus.LadIn    = 4'hF;
    for (int i = 0; i < 256; i++) regmem[i] = 8'($urandom);
    regmem[8'h0B] = 8'h3C;
    #1;
    check("rst_addr", 32'(bus.Addr), 32'd0);
    check("rst_wr", 32'(bus.Wr), 32'd0);
    check("rst_rd", 32'(bus.Rd), 32'd0);
    check("rst_wdata", 32'(bus.DataWrSW), 32'd0);
    check("rst_lad_out", 32'(bus.LadOut), 32'hF);
    check("rst_lad_oe", 32'(bus.LadOe), 32'd0);
    repeat (3) @(posedge LpcClock);
    #1 PciReset = 1'b1;

    lpc_cycle(1'b1, 16'h0809, 8'hA5, -1, 2);
    lpc_cycle(1'b0, 16'h080B, 8'h00, -1, 0);
    lpc_cycle(1'b1, 16'h0900, 8'h77, -1, 1);
    lpc_cycle(1'b1, 16'h0812, 8'h99, 7, 1);
    lpc_cycle(1'b0, 16'h081F, 8'h00, -1, 0);
    lpc_cycle(1'b0, 16'h0803, 8'h00, 5, 2);

    for (int n = 0; n < 40; n++) begin
      wr_sel = 1'($urandom);
      if ($urandom_range(3, 0) != 0) a = {BASE[15:5], 5'($urandom)};
      else begin
        a = 16'($urandom);
        while (a[15:5] == BASE[15:5]) a = 16'($urandom);
      end
      ab = ($urandom_range(4, 0) == 0) ? int'($urandom_range(wr_sel ? 9 : 7, 1)) : -1;
      lpc_cycle(wr_sel, a, 8'($urandom), ab, int'($urandom_range(3, 0)));
    end

    reset_in_rdata();
    lpc_cycle(1'b1, 16'h0801, 8'h5A, -1, 2);

    repeat (4) drive(1'b1, 4'hF);
    check("lad_queue_drained", lad_q.size(), 32'd0);
    check("strobe_queue_drained", strb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
